lvds_tx_pattern: RTL and testbench

Transmit-side pattern generator for the phase-binned LVDS link. It converts pulse requests into `NBINS`-bit words, one word per `clkin` cycle, where each word is one clock period split into `NBINS` phase bins. For each request it emits a run of `firingticks` consecutive high bins starting at a requested phase bin; the run may span word boundaries. It then enforces `deadticks` low bins before the next request. It drives the board's LVDS transmit lanes with the same bin ordering that the receive-side coincidence/histogram logic expects: bit 0 is the earliest bin.

---
 rtl/lvds_tx_pattern_if.sv | 27 ++
 rtl/lvds_tx_pattern.sv | 148 ++++++++++++++
 tb/tb_lvds_tx_pattern.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_pattern_if.sv
// Request channel of the LVDS transmit pattern generator: pulse request,
// its start phase, width and dead time, and the ready handshake.
interface lvds_tx_pattern_if #(
    parameter int unsigned PW = 3
);
    logic          req_valid;
    logic [PW-1:0] req_phase;
    logic          req_ready;
    logic [7:0]    firingticks;
    logic [7:0]    deadticks;

    modport master (
        output req_valid,
        output req_phase,
        output firingticks,
        output deadticks,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_phase,
        input  firingticks,
        input  deadticks,
        output req_ready
    );
endinterface

// File: rtl/lvds_tx_pattern.sv
// Phase-binned LVDS transmit pattern generator: turns pulse requests into
// NBINS-bit words (bit 0 = earliest bin) with a firing run and dead time.
module lvds_tx_pattern #(
    parameter int unsigned NBINS = 8,
    parameter int unsigned PW    = 3
) (
    input  logic              clkin,
    input  logic              rst,
    lvds_tx_pattern_if.slave  req,
    input  logic              test_en,
    input  logic [15:0]       test_period,
    input  logic              clr_count,
    output logic [NBINS-1:0]  lvds_tx,
    output logic              busy,
    output logic [31:0]       fire_count
);

    localparam int unsigned RW  = 9;
    localparam int unsigned CW  = 16;
    localparam int unsigned FCW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [RW-1:0]    rem_fire;
    logic [RW-1:0]    rem_dead;
    logic [RW-1:0]    rem_fire_n;
    logic [RW-1:0]    rem_dead_n;
    logic [NBINS-1:0] word_n;
    logic [CW-1:0]    test_cnt;
    logic [CW-1:0]    test_cnt_n;

    logic             test_fire_c;
    logic             accept_c;
    logic             emit_c;
    logic [PW-1:0]    start_c;
    logic [RW-1:0]    fire_in_c;
    logic [RW-1:0]    dead_in_c;
    logic [RW-1:0]    avail_c;
    logic [RW-1:0]    high_c;
    logic [RW-1:0]    rest_c;

    function automatic logic [RW-1:0] min_r(input logic [RW-1:0] a,
                                            input logic [RW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Ready is combinational so a held request is taken on the first IDLE edge
    assign req.req_ready = (state == IDLE) && !test_en && !rst;

    assign test_fire_c = test_en && (state == IDLE) && (test_cnt >= test_period);
    assign accept_c    = test_en ? test_fire_c : (req.req_valid && req.req_ready);

    // Next-state, bin word and remaining-bin bookkeeping
    always_comb begin
        state_n    = state;
        rem_fire_n = rem_fire;
        rem_dead_n = rem_dead;
        word_n     = '0;
        emit_c     = 1'b0;
        start_c    = '0;
        fire_in_c  = rem_fire;
        dead_in_c  = rem_dead;
        avail_c    = '0;
        high_c     = '0;
        rest_c     = '0;

        if (accept_c) begin
            emit_c    = 1'b1;
            start_c   = test_en ? '0 : req.req_phase;
            fire_in_c = (req.firingticks == 8'd0) ? RW'(1) : RW'(req.firingticks);
            dead_in_c = RW'(req.deadticks);
        end else if (state == FIRE) begin
            emit_c = 1'b1;
        end

        if (emit_c) begin
            avail_c = RW'(NBINS) - RW'(start_c);
            high_c  = min_r(fire_in_c, avail_c);
            for (int unsigned i = 0; i < NBINS; i++) begin
                word_n[i] = (RW'(i) >= RW'(start_c)) &&
                            (RW'(i) <  RW'(start_c) + high_c);
            end
            rem_fire_n = fire_in_c - high_c;
            rem_dead_n = dead_in_c;
            // Dead time starts in the bin right after the last high bin
            if (rem_fire_n == '0) begin
                rest_c     = avail_c - high_c;
                rem_dead_n = dead_in_c - min_r(dead_in_c, rest_c);
            end
        end else if (state == DEAD) begin
            rem_dead_n = rem_dead - min_r(rem_dead, RW'(NBINS));
        end

        if (rem_fire_n != '0) begin
            state_n = FIRE;
        end else if (rem_dead_n != '0) begin
            state_n = DEAD;
        end else begin
            state_n = IDLE;
        end
    end

    // Test-mode period counter; held at zero while test mode is off
    always_comb begin
        test_cnt_n = test_cnt;
        if (!test_en || test_fire_c) begin
            test_cnt_n = '0;
        end else if (test_cnt != '1) begin
            test_cnt_n = test_cnt + CW'(1);
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem_fire <= '0;
            rem_dead <= '0;
            lvds_tx  <= '0;
            busy     <= 1'b0;
            test_cnt <= '0;
        end else begin
            state    <= state_n;
            rem_fire <= rem_fire_n;
            rem_dead <= rem_dead_n;
            lvds_tx  <= word_n;
            busy     <= (state_n != IDLE);
            test_cnt <= test_cnt_n;
        end
    end

    // Clear wins over a coincident acceptance
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            fire_count <= '0;
        end else if (clr_count) begin
            fire_count <= '0;
        end else if (accept_c) begin
            fire_count <= fire_count + FCW'(1);
        end
    end

endmodule

// File: tb/tb_lvds_tx_pattern.sv
// Self-checking bench for lvds_tx_pattern: directed vector table plus
// hand-written sequences for held requests, clear, test mode and reset.
module tb_lvds_tx_pattern;

    localparam int unsigned NBINS = 8;
    localparam int unsigned PW    = 3;

    typedef struct packed {
        logic [2:0]      phase;
        logic [7:0]      fire;
        logic [7:0]      dead;
        logic [2:0]      n;
        logic [3:0][7:0] w;
    } vec_t;

    logic             clkin = 1'b0;
    logic             rst;
    logic             test_en;
    logic [15:0]      test_period;
    logic             clr_count;
    logic [NBINS-1:0] lvds_tx;
    logic             busy;
    logic [31:0]      fire_count;

    lvds_tx_pattern_if #(.PW(PW)) req_if ();

    lvds_tx_pattern #(.NBINS(NBINS), .PW(PW)) dut (
        .clkin       (clkin),
        .rst         (rst),
        .req         (req_if),
        .test_en     (test_en),
        .test_period (test_period),
        .clr_count   (clr_count),
        .lvds_tx     (lvds_tx),
        .busy        (busy),
        .fire_count  (fire_count)
    );

    always #5 clkin = ~clkin;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_fc   = 0;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] p, input logic [7:0] f, input logic [7:0] d,
                                input logic [2:0] n, input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3);
        vec_t r;
        r.phase = p;
        r.fire  = f;
        r.dead  = d;
        r.n     = n;
        r.w     = {w3, w2, w1, w0};
        return r;
    endfunction

    // Called at a falling edge; bounded wait for the generator to go idle
    task automatic wait_ready();
        for (int i = 0; i < 50 && req_if.req_ready !== 1'b1; i++) @(negedge clkin);
        check("wait_ready", 32'(req_if.req_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clkin);
        wait_ready();
        req_if.req_valid   = 1'b1;
        req_if.req_phase   = v.phase;
        req_if.firingticks = v.fire;
        req_if.deadticks   = v.dead;
        @(posedge clkin);
        #1;
        req_if.req_valid = 1'b0;
        exp_fc++;
        for (int k = 0; k < int'(v.n); k++) begin
            if (k > 0) begin
                @(posedge clkin);
                #1;
            end
            check($sformatf("v%0d word%0d", idx, k), 32'(lvds_tx), 32'(v.w[k]));
            check($sformatf("v%0d busy%0d", idx, k), 32'(busy), 32'(k < int'(v.n) - 1));
        end
        @(posedge clkin);
        #1;
        check($sformatf("v%0d idle_word", idx), 32'(lvds_tx), 32'd0);
        check($sformatf("v%0d fire_count", idx), fire_count, 32'(exp_fc));
        check($sformatf("v%0d ready", idx), 32'(req_if.req_ready), 32'd1);
    endtask

    initial begin
        //               phase fire   dead  n   words (first word first)
        vecs[0] = mk(3'd2, 8'd3,   8'd0,  3'd1, 8'h1C, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(3'd6, 8'd4,   8'd0,  3'd2, 8'hC0, 8'h03, 8'h00, 8'h00);
        vecs[2] = mk(3'd0, 8'd20,  8'd0,  3'd3, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        vecs[3] = mk(3'd7, 8'd2,   8'd10, 3'd3, 8'h80, 8'h01, 8'h00, 8'h00);
        vecs[4] = mk(3'd0, 8'd0,   8'd0,  3'd1, 8'h01, 8'h00, 8'h00, 8'h00);
        vecs[5] = mk(3'd5, 8'd3,   8'd2,  3'd2, 8'hE0, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(3'd3, 8'd8,   8'd0,  3'd2, 8'hF8, 8'h07, 8'h00, 8'h00);
        vecs[7] = mk(3'd1, 8'd2,   8'd3,  3'd1, 8'h06, 8'h00, 8'h00, 8'h00);
        vecs[8] = mk(3'd0, 8'd8,   8'd8,  3'd2, 8'hFF, 8'h00, 8'h00, 8'h00);

        rst                = 1'b1;
        test_en            = 1'b0;
        test_period        = 16'd0;
        clr_count          = 1'b0;
        req_if.req_valid   = 1'b0;
        req_if.req_phase   = '0;
        req_if.firingticks = 8'd0;
        req_if.deadticks   = 8'd0;

        #2;
        check("rst lvds_tx", 32'(lvds_tx), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst fire_count", fire_count, 32'd0);
        check("rst ready", 32'(req_if.req_ready), 32'd0);
        repeat (2) @(negedge clkin);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Held request while busy is taken on the first edge after IDLE
        @(negedge clkin);
        wait_ready();
        req_if.req_valid   = 1'b1;
        req_if.req_phase   = 3'd7;
        req_if.firingticks = 8'd2;
        req_if.deadticks   = 8'd10;
        @(posedge clkin); #1;
        check("hold w0", 32'(lvds_tx), 32'h80);
        exp_fc++;
        req_if.req_phase   = 3'd0;
        req_if.firingticks = 8'd1;
        req_if.deadticks   = 8'd0;
        @(posedge clkin); #1;
        check("hold w1", 32'(lvds_tx), 32'h01);
        check("hold ready_low", 32'(req_if.req_ready), 32'd0);
        check("hold count1", fire_count, 32'(exp_fc));
        @(posedge clkin); #1;
        check("hold w2", 32'(lvds_tx), 32'h00);
        check("hold busy2", 32'(busy), 32'd0);
        check("hold count2", fire_count, 32'(exp_fc));
        check("hold ready_high", 32'(req_if.req_ready), 32'd1);
        @(posedge clkin); #1;
        exp_fc++;
        check("hold w3", 32'(lvds_tx), 32'h01);
        check("hold count3", fire_count, 32'(exp_fc));
        req_if.req_valid = 1'b0;
        @(posedge clkin); #1;
        check("hold w4", 32'(lvds_tx), 32'h00);

        // Clear coinciding with an acceptance, then clear alone
        @(negedge clkin);
        wait_ready();
        req_if.req_valid   = 1'b1;
        req_if.req_phase   = 3'd0;
        req_if.firingticks = 8'd1;
        req_if.deadticks   = 8'd0;
        clr_count          = 1'b1;
        @(posedge clkin); #1;
        req_if.req_valid = 1'b0;
        clr_count        = 1'b0;
        exp_fc           = 0;
        check("clr+acc word", 32'(lvds_tx), 32'h01);
        check("clr+acc count", fire_count, 32'd0);
        run_vec(9, vecs[0]);
        @(negedge clkin);
        clr_count = 1'b1;
        @(posedge clkin); #1;
        clr_count = 1'b0;
        exp_fc    = 0;
        check("clr count", fire_count, 32'd0);

        // Test mode: periodic phase-0 pulses, external request ignored
        @(negedge clkin);
        test_en            = 1'b1;
        test_period        = 16'd4;
        req_if.req_valid   = 1'b1;
        req_if.req_phase   = 3'd3;
        req_if.firingticks = 8'd1;
        req_if.deadticks   = 8'd0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clkin); #1;
            check($sformatf("test word%0d", e), 32'(lvds_tx), (e % 5 == 0) ? 32'h01 : 32'h00);
            if (e % 5 == 1) check($sformatf("test ready%0d", e), 32'(req_if.req_ready), 32'd0);
        end
        exp_fc += 4;
        check("test count", fire_count, 32'(exp_fc));
        @(negedge clkin);
        test_en          = 1'b0;
        req_if.req_valid = 1'b0;

        // Asynchronous reset in the second word of a long pulse
        @(negedge clkin);
        wait_ready();
        req_if.req_valid   = 1'b1;
        req_if.req_phase   = 3'd0;
        req_if.firingticks = 8'd20;
        req_if.deadticks   = 8'd0;
        @(posedge clkin); #1;
        req_if.req_valid = 1'b0;
        check("rstmid w0", 32'(lvds_tx), 32'hFF);
        @(posedge clkin); #1;
        check("rstmid w1", 32'(lvds_tx), 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid async word", 32'(lvds_tx), 32'd0);
        check("rstmid ready", 32'(req_if.req_ready), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        @(posedge clkin);
        @(negedge clkin);
        rst = 1'b0;
        exp_fc = 0;
        #1;
        check("post-rst count", fire_count, 32'd0);
        check("post-rst ready", 32'(req_if.req_ready), 32'd1);
        check("post-rst word", 32'(lvds_tx), 32'd0);
        run_vec(10, mk(3'd4, 8'd0, 8'd0, 3'd1, 8'h10, 8'h00, 8'h00, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
